// File: rtl/spiker_result_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spiker_result_ctrl
// Description : Sequences one spiker inference. Launches the core on a
//               software start, waits for core done (with optional timeout),
//               snapshots the core result and streams it word by word into
//               the result registers. Provides busy/done/timeout status and
//               a one-cycle completion interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module spiker_result_ctrl #(
    parameter int WIDTH      = 32,
    parameter int N_REG      = 24,
    parameter int DATA_WIDTH = 768,   // must equal N_REG*WIDTH
    parameter int TIMEOUT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     done_clr_i,
    input  logic [TIMEOUT_W-1:0]     timeout_i,
    output logic                     core_start_o,
    input  logic                     core_done_i,
    input  logic [DATA_WIDTH-1:0]    core_data_i,
    output logic                     res_we_o,
    output logic [$clog2(N_REG)-1:0] res_idx_o,
    output logic [WIDTH-1:0]         res_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     irq_o
);

    localparam int c_idx_w = $clog2(N_REG);
    localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(N_REG - 1);
    localparam logic [c_idx_w-1:0]   c_idx_one  = c_idx_w'(1);
    localparam logic [TIMEOUT_W-1:0] c_cnt_one  = TIMEOUT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [TIMEOUT_W-1:0]   r_wait_cnt;
    logic [TIMEOUT_W-1:0]   w_wait_cnt_inc;
    logic                   w_timeout_hit;

    logic [DATA_WIDTH-1:0]  r_snap;
    logic [c_idx_w-1:0]     r_idx;
    logic                   w_idx_last;

    logic                   r_done;
    logic                   r_timeout;
    logic                   r_irq_to;

    logic                   w_accept_done;
    logic                   w_to_set;
    logic                   w_done_set;
    logic                   w_flag_clr;

    logic [WIDTH-1:0]       w_words [N_REG];

    // The snapshot viewed as an array of result words, word 0 in the LSBs.
    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_words
            assign w_words[gi] = r_snap[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Counter value at the end of this WAIT cycle; a zero limit never matches
    // so the controller waits forever.
    assign w_wait_cnt_inc = r_wait_cnt + c_cnt_one;
    assign w_timeout_hit  = (timeout_i != '0) && (w_wait_cnt_inc == timeout_i);
    assign w_idx_last     = (r_idx == c_last_idx);

    // A new start wipes the status of the previous inference.
    assign w_flag_clr     = done_clr_i || ((r_state == ST_IDLE) && start_i);

    // Next-state decode; abort overrides every other transition and event.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept_done = 1'b0;
        w_to_set      = 1'b0;
        w_done_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Done is checked first so it wins over a same-cycle timeout.
                if (core_done_i) begin
                    w_accept_done = 1'b1;
                    w_state_nxt   = ST_WRITE;
                end else if (w_timeout_hit) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (w_idx_last) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_done_set  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort_i && (r_state != ST_IDLE)) begin
            w_state_nxt   = ST_IDLE;
            w_accept_done = 1'b0;
            w_to_set      = 1'b0;
            w_done_set    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait counter: cleared on launch, advances on every WAIT cycle without done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_WAIT) && !core_done_i) begin
            r_wait_cnt <= w_wait_cnt_inc;
        end
    end

    // Result snapshot and write index; snapshot only moves on an accepted done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_snap <= '0;
            r_idx  <= '0;
        end else if (w_accept_done) begin
            r_snap <= core_data_i;
            r_idx  <= '0;
        end else if ((r_state == ST_WRITE) && !w_idx_last) begin
            r_idx  <= r_idx + c_idx_one;
        end
    end

    // Sticky status flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_flag_clr) begin
                r_done <= 1'b0;
            end
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (w_flag_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Timeout interrupt fires in the cycle after the expiry is detected.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_to <= 1'b0;
        end else begin
            r_irq_to <= w_to_set;
        end
    end

    assign core_start_o = (r_state == ST_LAUNCH);
    assign busy_o       = (r_state != ST_IDLE);
    assign res_we_o     = (r_state == ST_WRITE);
    assign res_idx_o    = (r_state == ST_WRITE) ? r_idx : '0;
    assign res_data_o   = (r_state == ST_WRITE) ? w_words[r_idx] : '0;
    assign done_o       = r_done;
    assign timeout_o    = r_timeout;
    assign irq_o        = w_done_set || r_irq_to;

endmodule
`default_nettype wire

// File: tb/tb_spiker_result_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spiker_result_ctrl
// Description : Self-checking bench for spiker_result_ctrl. Each inference is
//               planned on a cycle timeline; expected event cycles and write
//               contents are derived arithmetically from that plan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spiker_result_ctrl;

    localparam int WIDTH      = 32;
    localparam int N_REG      = 24;
    localparam int DATA_WIDTH = N_REG * WIDTH;
    localparam int TIMEOUT_W  = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start_i;
    logic                     abort_i;
    logic                     done_clr_i;
    logic [TIMEOUT_W-1:0]     timeout_i;
    logic                     core_start_o;
    logic                     core_done_i;
    logic [DATA_WIDTH-1:0]    core_data_i;
    logic                     res_we_o;
    logic [$clog2(N_REG)-1:0] res_idx_o;
    logic [WIDTH-1:0]         res_data_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     timeout_o;
    logic                     irq_o;

    always #5 clk = ~clk;

    spiker_result_ctrl #(
        .WIDTH      (WIDTH),
        .N_REG      (N_REG),
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .done_clr_i   (done_clr_i),
        .timeout_i    (timeout_i),
        .core_start_o (core_start_o),
        .core_done_i  (core_done_i),
        .core_data_i  (core_data_i),
        .res_we_o     (res_we_o),
        .res_idx_o    (res_idx_o),
        .res_data_o   (res_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .irq_o        (irq_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered over one planned inference (cycle 0 = start).
    int          obs_starts, obs_start_cyc, obs_irqs, obs_irq_cyc;
    int          obs_busy_fall, obs_done_rise, obs_to_rise;
    logic        obs_done_last, obs_to_last;
    int          widx [$];
    logic [31:0] wdat [$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_inputs();
        start_i     = 1'b0;
        abort_i     = 1'b0;
        done_clr_i  = 1'b0;
        core_done_i = 1'b0;
        core_data_i = '0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Record this cycle's outputs.
    task automatic sample(input int c);
        if (core_start_o) begin
            obs_starts++;
            if (obs_start_cyc < 0) obs_start_cyc = c;
        end
        if (res_we_o) begin
            widx.push_back(int'(res_idx_o));
            wdat.push_back(res_data_o);
        end
        if (irq_o) begin
            obs_irqs++;
            if (obs_irq_cyc < 0) obs_irq_cyc = c;
        end
        if (c >= 1 && !busy_o    && obs_busy_fall < 0) obs_busy_fall = c;
        if (c >= 1 && done_o     && obs_done_rise < 0) obs_done_rise = c;
        if (c >= 1 && timeout_o  && obs_to_rise   < 0) obs_to_rise   = c;
        obs_done_last = done_o;
        obs_to_last   = timeout_o;
    endtask

    // One inference: core answers d cycles after its launch pulse; tmo is the
    // WAIT limit; abort_k >= 0 aborts on the write of that index; noise adds
    // ignored starts and ignored core_done pulses; clr pulses done_clr on the
    // completion cycle and again two cycles later.
    task automatic run_op(input string name, input int d, input int tmo, input int abort_k,
                          input bit noise, input bit clr, input bit patterned);
        logic [31:0]           words [N_REG];
        logic [DATA_WIDTH-1:0] payload;
        int                    dcyc;
        int                    len;
        int                    nw;
        bit                    timed;
        dcyc  = 1 + d;
        len   = d + N_REG + 8;
        timed = (tmo != 0) && (tmo < d);
        for (int k = 0; k < N_REG; k++) begin
            words[k] = patterned ? (32'hA500_0000 + 32'(k)) : $urandom();
            payload[k*WIDTH +: WIDTH] = words[k];
        end
        obs_starts = 0; obs_start_cyc = -1; obs_irqs = 0; obs_irq_cyc = -1;
        obs_busy_fall = -1; obs_done_rise = -1; obs_to_rise = -1;
        widx.delete();
        wdat.delete();
        timeout_i = TIMEOUT_W'(tmo);
        for (int c = 0; c < len; c++) begin
            start_i     = (c == 0) ||
                          (noise && c >= 2 && c <= dcyc + N_REG && $urandom_range(3) == 0);
            core_done_i = (c == dcyc) || (noise && c > dcyc && $urandom_range(3) == 0);
            core_data_i = (c == dcyc) ? payload : {N_REG{$urandom()}};
            abort_i     = (abort_k >= 0) && (c == dcyc + 1 + abort_k);
            done_clr_i  = clr && ((c == dcyc + N_REG + 1) || (c == dcyc + N_REG + 3));
            #2;
            sample(c);
            @(posedge clk);
            #1;
        end
        clear_inputs();

        check({name, "/launch_count"}, obs_starts, 1);
        check({name, "/launch_cycle"}, obs_start_cyc, 1);
        if (timed) begin
            nw = 0;
            check({name, "/irq_count"},    obs_irqs, 1);
            check({name, "/irq_cycle"},    obs_irq_cyc, tmo + 2);
            check({name, "/timeout_rise"}, obs_to_rise, tmo + 2);
            check({name, "/busy_fall"},    obs_busy_fall, tmo + 2);
            check({name, "/done_rise"},    obs_done_rise, -1);
            check({name, "/timeout_end"},  obs_to_last, 1);
        end else if (abort_k >= 0) begin
            nw = abort_k + 1;
            check({name, "/irq_count"},    obs_irqs, 0);
            check({name, "/busy_fall"},    obs_busy_fall, dcyc + abort_k + 2);
            check({name, "/done_rise"},    obs_done_rise, -1);
            check({name, "/timeout_rise"}, obs_to_rise, -1);
        end else begin
            nw = N_REG;
            check({name, "/irq_count"},    obs_irqs, 1);
            check({name, "/irq_cycle"},    obs_irq_cyc, dcyc + N_REG + 1);
            check({name, "/done_rise"},    obs_done_rise, dcyc + N_REG + 2);
            check({name, "/busy_fall"},    obs_busy_fall, dcyc + N_REG + 2);
            check({name, "/timeout_rise"}, obs_to_rise, -1);
            check({name, "/done_end"},     obs_done_last, clr ? 0 : 1);
        end
        check({name, "/write_count"}, widx.size(), nw);
        for (int i = 0; i < nw && i < widx.size(); i++) begin
            check($sformatf("%s/write%0d_idx", name, i), widx[i], i);
            check($sformatf("%s/write%0d_data", name, i), wdat[i], words[i]);
        end
    endtask

    initial begin
        int          mode;
        int          d;
        int          tmo;
        logic [31:0] rw;
        rst_n     = 1'b0;
        timeout_i = '0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy",       busy_o, 0);
        check("reset/done",       done_o, 0);
        check("reset/timeout",    timeout_o, 0);
        check("reset/irq",        irq_o, 0);
        check("reset/we",         res_we_o, 0);
        check("reset/core_start", core_start_o, 0);
        check("reset/idx",        res_idx_o, 0);
        check("reset/data",       res_data_o, 0);
        rst_n = 1'b1;
        idle(2);

        run_op("T1", 5, 0, -1, 1'b0, 1'b0, 1'b1);
        idle(2);
        run_op("T2", 30, 10, -1, 1'b0, 1'b0, 1'b0);
        idle(2);
        run_op("T3", 3, 3, -1, 1'b0, 1'b0, 1'b0);
        idle(2);
        run_op("T4a", 4, 0, 7, 1'b0, 1'b0, 1'b0);
        run_op("T4b", 2, 0, -1, 1'b0, 1'b0, 1'b0);
        idle(1);
        run_op("T5", 6, 0, -1, 1'b1, 1'b0, 1'b0);
        idle(2);
        run_op("abort_last", 1, 0, N_REG - 1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the transfer (write of idx 12).
        timeout_i = '0;
        for (int c = 0; c < 16; c++) begin
            start_i     = (c == 0);
            core_done_i = (c == 3);
            core_data_i = {N_REG{32'h5A5A_0000 + 32'(c)}};
            @(posedge clk);
            #1;
        end
        clear_inputs();
        #1;
        check("T6/we_before_reset",  res_we_o, 1);
        check("T6/idx_before_reset", res_idx_o, 12);
        rst_n = 1'b0;
        #1;
        check("T6/busy",    busy_o, 0);
        check("T6/we",      res_we_o, 0);
        check("T6/idx",     res_idx_o, 0);
        check("T6/data",    res_data_o, 0);
        check("T6/irq",     irq_o, 0);
        check("T6/done",    done_o, 0);
        check("T6/timeout", timeout_o, 0);
        @(posedge clk);
        #1;
        check("T6/busy_held", busy_o, 0);
        rst_n = 1'b1;
        idle(2);
        run_op("T6_clr", 3, 0, -1, 1'b0, 1'b1, 1'b0);
        idle(1);

        for (int it = 0; it < 20; it++) begin
            mode = int'($urandom_range(3));
            d    = int'($urandom_range(12, 2));
            case (mode)
                0: begin
                    rw  = $urandom_range(1);
                    tmo = (rw == 0) ? 0 : int'($urandom_range(40, d + 1));
                    run_op($sformatf("R%0d_norm", it), d, tmo, -1,
                           1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
                end
                1: run_op($sformatf("R%0d_tmo", it), d, int'($urandom_range(d - 1, 1)), -1,
                          1'b0, 1'b0, 1'b0);
                2: run_op($sformatf("R%0d_abort", it), d, 0, int'($urandom_range(N_REG - 1)),
                          1'b0, 1'b0, 1'b0);
                default: run_op($sformatf("R%0d_tie", it), d, d, -1, 1'b0, 1'b0, 1'b0);
            endcase
            idle(int'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
